// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: the operation code seen by
// the decoder and the MDU, controller states, default latencies and the
// result bundle produced by the arithmetic block.
package mdu_pkg;

  // Operation codes; the decoder emits exactly these values on the op bus.
  typedef enum logic [2:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6
  } mdu_op_e;

  // Sequencer states.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  // Default busy latencies in cycles.
  localparam int MDU_MULT_CYCLES = 5;
  localparam int MDU_DIV_CYCLES  = 10;

  // 64-bit result split into its HI/LO halves, plus a flag telling the
  // controller not to commit (divide by zero leaves HI/LO untouched).
  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_zero;
  } mdu_result_t;

  // True for the operations that occupy the unit for several cycles.
  function automatic logic is_long_op(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_DIV)  || (op == MDU_DIVU);
  endfunction

  // True for the two divide operations.
  function automatic logic is_div_op(input logic [2:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath. Produces the full HI/LO result for
// a long MDU operation in one evaluation; the controller captures it into a
// shadow register and releases it after the architectural latency.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output mdu_result_t res
);

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic               b_zero;
  logic               div_ovf;
  logic        [31:0] div_s_b;
  logic        [31:0] div_u_b;
  logic signed [31:0] quot_s;
  logic signed [31:0] rem_s;
  logic        [31:0] quot_u;
  logic        [31:0] rem_u;

  // Full-width products; operands are extended explicitly so the multiply
  // is 64 bits wide in both signednesses.
  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};

  assign b_zero  = (b == 32'd0);
  // Most-negative / -1 overflows a 32-bit signed quotient. Dividing by 1
  // instead yields exactly the defined answer (quotient 0x80000000,
  // remainder 0), so the overflow case simply swaps the divisor.
  assign div_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

  // Zero divisors are replaced by 1 so the divider never sees zero; the
  // result is discarded at commit anyway via div_zero.
  assign div_s_b = (b_zero || div_ovf) ? 32'd1 : b;
  assign div_u_b = b_zero ? 32'd1 : b;

  // Signed division truncates toward zero and the remainder takes the
  // dividend's sign, which is what the architecture wants.
  assign quot_s = $signed(a) / $signed(div_s_b);
  assign rem_s  = $signed(a) % $signed(div_s_b);
  assign quot_u = a / div_u_b;
  assign rem_u  = a % div_u_b;

  // Select the result for the requested operation.
  always_comb begin
    res = '0;
    case (op)
      MDU_MULT: begin
        res.hi = prod_s[63:32];
        res.lo = prod_s[31:0];
      end
      MDU_MULTU: begin
        res.hi = prod_u[63:32];
        res.lo = prod_u[31:0];
      end
      MDU_DIV: begin
        res.hi       = rem_s;
        res.lo       = quot_s;
        res.div_zero = b_zero;
      end
      MDU_DIVU: begin
        res.hi       = rem_u;
        res.lo       = quot_u;
        res.div_zero = b_zero;
      end
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller with the architectural HI/LO registers.
// A long operation computes its result at issue, parks it in a shadow
// register and commits it after a fixed busy latency; MTHI/MTLO write the
// registers directly. busy feeds the hazard unit and is a pure flop output.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  mdu_state_e       state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  mdu_result_t      shadow_q, shadow_d;
  logic [31:0]      hi_q,     hi_d;
  logic [31:0]      lo_q,     lo_d;
  mdu_result_t      arith_res;

  mdu_arith u_arith (
    .op  (op),
    .a   (a),
    .b   (b),
    .res (arith_res)
  );

  // State, counter, shadow and HI/LO registers; asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // Sequencing: issue from IDLE, count down in RUN, commit on the last busy
  // cycle. flush overrides everything, including a same-cycle commit or
  // issue, and leaves HI/LO as they were.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (is_long_op(op)) begin
            shadow_d = arith_res;
            cnt_d    = is_div_op(op) ? DIV_LOAD : MULT_LOAD;
            state_d  = ST_RUN;
          end else if (op == MDU_MTHI) begin
            hi_d = a;
          end else if (op == MDU_MTLO) begin
            lo_d = a;
          end
        end
      end
      ST_RUN: begin
        // start is not expected here; the hazard unit holds MDU ops in D.
        if (cnt_q <= CNT_ONE) begin
          if (!shadow_q.div_zero) begin
            hi_d = shadow_q.hi;
            lo_d = shadow_q.lo;
          end
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (flush) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      shadow_d = shadow_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: directed vectors with literal expectations, plus a
// cycle-by-cycle reference model that predicts busy/HI/LO from the
// architectural rules using plain integer arithmetic.
module tb_mdu_ctrl;
  import mdu_pkg::*;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  op    = 3'd0;
  logic [31:0] a     = 32'd0;
  logic [31:0] b     = 32'd0;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_hi  = 32'd0;
  logic [31:0] m_lo  = 32'd0;
  logic [31:0] m_phi = 32'd0;
  logic [31:0] m_plo = 32'd0;
  logic        m_pdz = 1'b0;
  int          m_left = 0;

  task automatic model_issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    int          sx;
    int          sy;
    longint      ps;
    logic [63:0] pu;
    sx = x;
    sy = y;
    m_pdz = 1'b0;
    case (o)
      MDU_MULT: begin
        ps = longint'(sx) * longint'(sy);
        {m_phi, m_plo} = ps;
        m_left = 5;
      end
      MDU_MULTU: begin
        pu = {32'd0, x} * {32'd0, y};
        {m_phi, m_plo} = pu;
        m_left = 5;
      end
      MDU_DIV: begin
        m_left = 10;
        if (y == 32'd0) m_pdz = 1'b1;
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          m_plo = 32'h8000_0000;
          m_phi = 32'd0;
        end else begin
          m_plo = sx / sy;
          m_phi = sx % sy;
        end
      end
      MDU_DIVU: begin
        m_left = 10;
        if (y == 32'd0) m_pdz = 1'b1;
        else begin
          m_plo = x / y;
          m_phi = x % y;
        end
      end
      MDU_MTHI: m_hi = x;
      MDU_MTLO: m_lo = x;
      default: ;
    endcase
  endtask

  // Compare DUT against model on every falling edge, then advance the model
  // with the inputs the next rising edge will sample.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_hi   = 32'd0;
        m_lo   = 32'd0;
        m_left = 0;
      end
      chk("model_busy", {31'd0, busy}, {31'd0, (m_left > 0)});
      chk("model_hi", hi, m_hi);
      chk("model_lo", lo, m_lo);
      if (rst_n) begin
        if (flush) begin
          m_left = 0;
        end else if (m_left > 0) begin
          assert (!start) else $error("stimulus issued start while unit busy");
          m_left = m_left - 1;
          if (m_left == 0 && !m_pdz) begin
            m_hi = m_phi;
            m_lo = m_plo;
          end
        end else if (start) begin
          model_issue(op, a, b);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    tick();
    start = 1'b0;
    op    = 3'd0;
    a     = 32'd0;
    b     = 32'd0;
  endtask

  // Count busy cycles after issue, bounded so a stuck unit cannot hang.
  task automatic wait_idle(input string name, output int n);
    n = 0;
    while (busy === 1'b1 && n < 60) begin
      n++;
      tick();
    end
    if (busy !== 1'b0) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: busy still 0x%0h after %0d cycles, required 0", name, busy, n);
    end
  endtask

  task automatic run_long(input string name, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input int cyc,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    issue(o, x, y);
    wait_idle(name, n);
    chk({name, "_cycles"}, 32'(n), 32'(cyc));
    chk({name, "_hi"}, hi, exp_hi);
    chk({name, "_lo"}, lo, exp_lo);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    rst_n = 1'b0;
    tick();
    tick();
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    rst_n = 1'b1;
    tick();

    run_long("mult_neg2x3",  MDU_MULT,  32'hFFFF_FFFE, 32'd3,         5,  32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_long("multu_max",    MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,  32'hFFFF_FFFE, 32'h0000_0001);
    run_long("div_m7_by2",   MDU_DIV,   32'hFFFF_FFF9, 32'd2,         10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    issue(MDU_MTHI, 32'hAAAA_5555, 32'd0);
    issue(MDU_MTLO, 32'h0F0F_0F0F, 32'd0);
    run_long("divu_by_zero", MDU_DIVU,  32'd7,         32'd0,         10, 32'hAAAA_5555, 32'h0F0F_0F0F);
    run_long("div_overflow", MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000);

    issue(MDU_MTHI, 32'h1234_5678, 32'd0);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    chk("mthi_hi", hi, 32'h1234_5678);
    chk("mthi_lo_kept", lo, 32'h8000_0000);
    issue(MDU_MTLO, 32'h9ABC_DEF0, 32'd0);
    chk("mtlo_lo", lo, 32'h9ABC_DEF0);
    chk("mtlo_hi_kept", hi, 32'h1234_5678);
    tick();
    chk("mtlo_busy", {31'd0, busy}, 32'd0);

    issue(MDU_NONE, 32'hDEAD_BEEF, 32'd1);
    issue(3'd7, 32'hDEAD_BEEF, 32'd1);
    chk("noop_busy", {31'd0, busy}, 32'd0);
    chk("noop_hi", hi, 32'h1234_5678);
    chk("noop_lo", lo, 32'h9ABC_DEF0);

    run_long("divu_100_7",   MDU_DIVU,  32'd100,       32'd7,         10, 32'd2,         32'd14);
    run_long("div_7_m2",     MDU_DIV,   32'd7,         32'hFFFF_FFFE, 10, 32'd1,         32'hFFFF_FFFD);
    run_long("div_m7_m2",    MDU_DIV,   32'hFFFF_FFF9, 32'hFFFF_FFFE, 10, 32'hFFFF_FFFF, 32'd3);
    run_long("mult_maxpos",  MDU_MULT,  32'h7FFF_FFFF, 32'h7FFF_FFFF, 5,  32'h3FFF_FFFF, 32'h0000_0001);
    run_long("mult_minneg",  MDU_MULT,  32'h8000_0000, 32'hFFFF_FFFF, 5,  32'h0000_0000, 32'h8000_0000);
    run_long("divu_big",     MDU_DIVU,  32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h8000_0000, 32'h0000_0000);

    // Flush during the third busy cycle of a MULT; a start right after is accepted.
    issue(MDU_MULT, 32'd3, 32'd4);
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_hi", hi, 32'h8000_0000);
    chk("flush_lo", lo, 32'h0000_0000);
    run_long("after_flush",  MDU_MULTU, 32'd5,         32'd6,         5,  32'd0,         32'd30);

    // flush beats a same-cycle MTHI.
    flush = 1'b1;
    issue(MDU_MTHI, 32'h0000_0055, 32'd0);
    flush = 1'b0;
    chk("flush_mthi_hi", hi, 32'd0);

    // Asynchronous reset in the middle of a DIV.
    issue(MDU_MTHI, 32'hCAFE_0001, 32'd0);
    issue(MDU_MTLO, 32'hCAFE_0002, 32'd0);
    issue(MDU_DIV, 32'd100, 32'd3);
    tick();
    tick();
    chk("rst_pre_busy", {31'd0, busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_hi", hi, 32'd0);
    chk("async_rst_lo", lo, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    run_long("recover_mult", MDU_MULT,  32'd6,         32'd7,         5,  32'd0,         32'd42);

    wait_idle("final", n);
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time 0x%0h exceeded, required completion earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multi-cycle multiply/divide unit with its sequencing controller and the architectural HI/LO registers. Sits in the E stage beside the ALU; it takes the decoded MDU operation and operands, holds itself busy for a fixed latency, and commits results to HI/LO. Its `busy` output drives the hazard unit, which stalls any MDU-class instruction in D (MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO) while `start | busy`.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for MULT/MULTU (≥1).
- `DIV_CYCLES`, default 10: busy cycles for DIV/DIVU (≥1).

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  E-stage instruction is an MDU op; samples `op`, `a`, `b`.
- `op`  in  3  MDU operation code (package enum).
- `a`  in  32  rs operand (dividend / multiplicand / MTHI-MTLO data).
- `b`  in  32  rt operand (divisor / multiplier).
- `flush`  in  1  abort in-flight op (exception/interrupt).
- `busy`  out  1  operation in progress.
- `hi`  out  32  HI register (read by MFHI).
- `lo`  out  32  LO register (read by MFLO).

## Operation
- States: IDLE, RUN. Reset: state=IDLE, counter=0, `busy`=0, `hi`=0, `lo`=0, shadow result=0.
- IDLE, `start`, op ∈ {MULT, MULTU, DIV, DIVU}: compute 64-bit result into shadow regs; load counter with MULT_CYCLES or DIV_CYCLES; go RUN.
- IDLE, `start`, op=MTHI/MTLO: write `a` to HI/LO at that edge; stay IDLE, `busy` never asserts.
- `start` with op=NONE or an undefined code: no effect.
- RUN: decrement counter each cycle; when counter reaches 1, commit shadow to HI/LO at that edge, go IDLE.
- `start` while RUN: ignored (hazard unit guarantees it cannot occur; assertion in bench).
- `flush` (any state): go IDLE at next edge, counter=0, HI/LO unchanged, in-flight result discarded. `flush` has priority over `start` and over commit in the same cycle.
- Arithmetic:
  - MULT: signed 32×32→64; HI=product[63:32], LO=product[31:0].
  - MULTU: unsigned, same split.
  - DIV: signed; LO=quotient truncated toward zero, HI=remainder with dividend's sign.
  - DIVU: unsigned quotient/remainder.
  - 0x80000000 DIV 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divide by zero (b=0, DIV or DIVU): operation runs full latency; HI/LO unchanged at commit.

## Timing
- `start` sampled at edge T0 → `busy`=1 for cycles T0+1 … T0+N (N = latency); HI/LO new values and `busy`=0 visible from T0+N+1.
- `busy` is a register output; no combinational path from inputs to `busy`.
- `hi`/`lo` are registered; MFHI/MFLO in E read them directly (hazard unit already stalled them through `busy`).
- MTHI/MTLO: new value visible the cycle after `start`.
- `flush` at edge Tf while RUN → `busy`=0 from Tf+1; a `start` at Tf+1 is accepted normally.
- `rst_n` low mid-operation: immediate return to reset values, independent of `clk`.

## Structure
- Shared package `mdu_pkg`: `op` enum (NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6), latency defaults; decoder emits the same enum.
- One natural sub-module `mdu_arith`: combinational 64-bit result from op/a/b, including DIV overflow and zero-divisor flag. Controller FSM, counter, shadow and HI/LO registers in `mdu_ctrl`.

## Test plan
- Reset then MULT a=0xFFFFFFFE (−2), b=3 → `busy` high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
- DIV a=−7 (0xFFFFFFF9), b=2 → `busy` 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU a=7, b=0 with HI/LO preset → unchanged after 10 cycles.
- DIV 0x80000000 by 0xFFFFFFFF → LO=0x80000000, HI=0.
- MTHI a=0x12345678 → HI=0x12345678 next cycle, `busy` stays 0; then MTLO → LO updated, HI kept.
- MULT started, `flush` on 3rd busy cycle → `busy`=0 next cycle, HI/LO keep prior values; `rst_n` pulsed low mid-DIV → `busy`, HI, LO = 0 immediately.
